qpsk_mapper: RTL and testbench

- Downstream neighbour of the interleaver in the WiMAX transmit chain.
- Consumes the interleaver's bit-serial output, one bit per accepted cycle.
- Pairs consecutive bits into QPSK symbols and maps each pair to signed fixed-point I/Q samples.
- Presents the symbols to the IFFT/subcarrier-mapping stage over a valid/ready handshake, with a per-block symbol index and a last-symbol flag.

---
 rtl/qpsk_mapper.sv | 106 ++++++++++
 tb/tb_qpsk_mapper.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_mapper.sv
// qpsk_mapper: pairs bit-serial interleaver output into Gray-mapped QPSK
// symbols (I from b0, Q from b1, 0 -> +AMP, 1 -> -AMP) and presents them
// through a single-entry output register with valid/ready handshake.
module qpsk_mapper #(
  parameter int              NCBPS = 192,
  parameter int              W     = 16,
  parameter logic [W-1:0]    AMP   = 16'h5A82,
  localparam int             NSYM  = NCBPS / 2,
  localparam int             IW    = $clog2(NSYM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_interleaver,
  input  logic          data_in,
  output logic          ready_mod,
  input  logic          ready_fft,
  output logic          valid_mod,
  output logic [W-1:0]  I_out,
  output logic [W-1:0]  Q_out,
  output logic [IW-1:0] sym_index,
  output logic          sym_last
);

  localparam logic [W-1:0]  NEG_AMP  = -AMP;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSYM - 1);

  logic          phase_q, phase_d;
  logic          b0_q, b0_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  i_q, i_d;
  logic [W-1:0]  q_q, q_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_q, last_d;

  logic accept, form, consume;

  // A phase-1 bit only stalls when the output slot is full and not draining;
  // phase-0 bits just fill b0 so they are always taken.
  always_comb begin
    ready_mod = !phase_q || !valid_q || ready_fft;
    accept    = valid_interleaver && ready_mod;
    form      = accept && phase_q;
    consume   = valid_q && ready_fft;
  end

  // Next-state: bit pairing, block counter and output register load/drain.
  always_comb begin
    phase_d = phase_q;
    b0_d    = b0_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    i_d     = i_q;
    q_d     = q_q;
    idx_d   = idx_q;
    last_d  = last_q;

    if (accept) begin
      phase_d = !phase_q;
      if (!phase_q) b0_d = data_in;
    end

    if (form) begin
      // New symbol replaces any one consumed at this same edge.
      valid_d = 1'b1;
      i_d     = b0_q    ? NEG_AMP : AMP;
      q_d     = data_in ? NEG_AMP : AMP;
      idx_d   = cnt_q;
      last_d  = (cnt_q == LAST_IDX);
      cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + IW'(1);
    end else if (consume) begin
      // Data fields keep their last values; only valid drops.
      valid_d = 1'b0;
    end
  end

  // State register; reset discards any half pair and pending symbol.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
      b0_q    <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      b0_q    <= b0_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      i_q     <= i_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign valid_mod = valid_q;
  assign I_out     = i_q;
  assign Q_out     = q_q;
  assign sym_index = idx_q;
  assign sym_last  = last_q;

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed bench for qpsk_mapper: reset, constellation, full blocks,
// backpressure, input gaps and asynchronous reset mid-block.
module tb_qpsk_mapper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_interleaver = 1'b0;
  logic        data_in = 1'b0;
  logic        ready_mod;
  logic        ready_fft = 1'b1;
  logic        valid_mod;
  logic [15:0] I_out;
  logic [15:0] Q_out;
  logic [6:0]  sym_index;
  logic        sym_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [191:0] blk_hex = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
  logic         bits [192];

  qpsk_mapper dut (
    .clk(clk), .reset(reset),
    .valid_interleaver(valid_interleaver), .data_in(data_in),
    .ready_mod(ready_mod), .ready_fft(ready_fft),
    .valid_mod(valid_mod), .I_out(I_out), .Q_out(Q_out),
    .sym_index(sym_index), .sym_last(sym_last)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] amp(input logic b);
    return b ? 16'hA57E : 16'h5A82;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    valid_interleaver = 1'b0;
    ready_fft = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    n_checks++;
    if (valid_mod !== 1'b0 || I_out !== 16'h0 || Q_out !== 16'h0 ||
        sym_index !== 7'd0 || sym_last !== 1'b0 || ready_mod !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%b I=%h Q=%h idx=%0d last=%b rdy=%b, want v=0 I=0 Q=0 idx=0 last=0 rdy=1",
               valid_mod, I_out, Q_out, sym_index, sym_last, ready_mod);
    end
    @(posedge clk); #1;
  endtask

  // Bits 0,1,0,0,1,0,1,1 from a fresh block, ready_fft=1; checked after each edge.
  task automatic check_const(input string tag);
    logic [7:0]  pat = 8'b0100_1011;
    logic [15:0] ei [4] = '{16'h5A82, 16'h5A82, 16'hA57E, 16'hA57E};
    logic [15:0] eq [4] = '{16'hA57E, 16'h5A82, 16'h5A82, 16'hA57E};
    ready_fft = 1'b1;
    for (int t = 0; t < 8; t++) begin
      valid_interleaver = 1'b1;
      data_in = pat[7 - t];
      @(posedge clk); #1;
      n_checks++;
      if (t % 2 == 1) begin
        if (valid_mod !== 1'b1 || I_out !== ei[t/2] || Q_out !== eq[t/2] ||
            sym_index !== 7'(t/2) || sym_last !== 1'b0) begin
          n_fail++;
          $display("FAIL %s sym%0d: got v=%b I=%h Q=%h idx=%0d last=%b, want v=1 I=%h Q=%h idx=%0d last=0",
                   tag, t/2, valid_mod, I_out, Q_out, sym_index, sym_last, ei[t/2], eq[t/2], t/2);
        end
      end else if (valid_mod !== 1'b0) begin
        n_fail++;
        $display("FAIL %s gap%0d: got valid_mod=%b, want 0", tag, t, valid_mod);
      end
    end
    valid_interleaver = 1'b0;
  endtask

  task automatic test_constellation();
    do_reset();
    check_const("constellation");
  endtask

  // Streams nbits from the reference block (repeating), ready_fft=1, and
  // checks every consumed symbol against the bit-pair mapping.
  task automatic run_stream(input int nbits, input bit gaps, input bit chk_gap, input string tag);
    int bptr = 0, sidx = 0, cyc = 0, last_cyc = -1, j;
    logic b0e, b1e;
    ready_fft = 1'b1;
    while (sidx < nbits / 2 && cyc < nbits * 4 + 20) begin
      valid_interleaver = (bptr < nbits) && (!gaps || $urandom_range(0, 1) == 1);
      data_in = bits[bptr % 192];
      #3;
      if (valid_mod && ready_fft) begin
        j   = sidx % 96;
        b0e = bits[(2 * sidx) % 192];
        b1e = bits[(2 * sidx + 1) % 192];
        n_checks++;
        if (I_out !== amp(b0e) || Q_out !== amp(b1e) || sym_index !== 7'(j) ||
            sym_last !== 1'(j == 95)) begin
          n_fail++;
          $display("FAIL %s sym%0d: got I=%h Q=%h idx=%0d last=%b, want I=%h Q=%h idx=%0d last=%b",
                   tag, sidx, I_out, Q_out, sym_index, sym_last, amp(b0e), amp(b1e), j, j == 95);
        end
        if (chk_gap && last_cyc >= 0) begin
          n_checks++;
          if (cyc - last_cyc != 2) begin
            n_fail++;
            $display("FAIL %s spacing%0d: got %0d cycles, want 2", tag, sidx, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        sidx++;
      end
      if (valid_interleaver && ready_mod) bptr++;
      @(posedge clk); #1;
      cyc++;
    end
    valid_interleaver = 1'b0;
    n_checks++;
    if (sidx != nbits / 2) begin
      n_fail++;
      $display("FAIL %s count: got %0d symbols, want %0d (cycle budget)", tag, sidx, nbits / 2);
    end
  endtask

  task automatic test_full_blocks();
    do_reset();
    run_stream(384, 1'b0, 1'b1, "full_blocks");
  endtask

  task automatic test_gaps();
    do_reset();
    run_stream(192, 1'b1, 1'b0, "gaps");
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_fft = 1'b0;
    valid_interleaver = 1'b1;
    data_in = 1'b0;
    @(posedge clk); #1;
    data_in = 1'b1;
    @(posedge clk); #1;
    // symbol (0,1) pending; next pair is (1,1)
    data_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #3;
      n_checks++;
      if (valid_mod !== 1'b1 || I_out !== 16'h5A82 || Q_out !== 16'hA57E ||
          sym_index !== 7'd0 || sym_last !== 1'b0 || ready_mod !== 1'(c == 0)) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%b I=%h Q=%h idx=%0d rdy=%b, want v=1 I=5a82 Q=a57e idx=0 rdy=%b",
                 c, valid_mod, I_out, Q_out, sym_index, ready_mod, c == 0);
      end
      @(posedge clk); #1;
    end
    ready_fft = 1'b1;
    #3;
    n_checks++;
    if (ready_mod !== 1'b1 || valid_mod !== 1'b1 || I_out !== 16'h5A82) begin
      n_fail++;
      $display("FAIL drain_edge: got rdy=%b v=%b I=%h, want rdy=1 v=1 I=5a82", ready_mod, valid_mod, I_out);
    end
    @(posedge clk); #1;
    valid_interleaver = 1'b0;
    n_checks++;
    if (valid_mod !== 1'b1 || I_out !== 16'hA57E || Q_out !== 16'hA57E || sym_index !== 7'd1) begin
      n_fail++;
      $display("FAIL stalled_pair: got v=%b I=%h Q=%h idx=%0d, want v=1 I=a57e Q=a57e idx=1",
               valid_mod, I_out, Q_out, sym_index);
    end
    @(posedge clk); #1;
    n_checks++;
    if (valid_mod !== 1'b0 || I_out !== 16'hA57E || sym_index !== 7'd1) begin
      n_fail++;
      $display("FAIL after_drain: got v=%b I=%h idx=%0d, want v=0 I=a57e idx=1", valid_mod, I_out, sym_index);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 36; k++) begin
      valid_interleaver = 1'b1;
      data_in = bits[k];
      @(posedge clk); #1;
    end
    ready_fft = 1'b0;
    data_in = bits[36];
    @(posedge clk); #1;
    valid_interleaver = 1'b0;
    n_checks++;
    if (valid_mod !== 1'b1 || sym_index !== 7'd17) begin
      n_fail++;
      $display("FAIL pre_reset: got v=%b idx=%0d, want v=1 idx=17", valid_mod, sym_index);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (valid_mod !== 1'b0 || I_out !== 16'h0 || Q_out !== 16'h0 ||
        sym_index !== 7'd0 || ready_mod !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b I=%h Q=%h idx=%0d rdy=%b, want v=0 I=0 Q=0 idx=0 rdy=1",
               valid_mod, I_out, Q_out, sym_index, ready_mod);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    check_const("after_reset");
  endtask

  initial begin
    for (int k = 0; k < 192; k++) bits[k] = blk_hex[191 - k];
    test_reset();
    test_constellation();
    test_full_blocks();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
